alu_result_fifo: RTL and testbench

//  Downstream stage of the 4-bit ALU. Captures each ALU result and its operands/flags
//  (a, b, select, out, zero, carry, sign, parity, overflow) into a FIFO.

---
 rtl/alu_result_fifo.sv | 85 ++++++++
 tb/tb_alu_result_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Result FIFO behind the 4-bit ALU: stores operands, result and flags per operation
// and hands them to a consumer over valid/ready, with saturating event counters.
module alu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [1:0]       in_select,
    input  logic [3:0]       in_out,
    input  logic [4:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_a,
    output logic [3:0]       out_b,
    output logic [1:0]       out_select,
    output logic [3:0]       out_out,
    output logic [4:0]       out_flags,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] ovf_count,
    output logic [CNT_W-1:0] drop_count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [18:0]   mem [DEPTH];
    logic [18:0]   head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign in_ready  = !full && !flush;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head is read straight from storage; zeroed while empty so stale data never leaks.
    assign head = empty ? '0 : mem[rd_ptr];
    assign {out_a, out_b, out_select, out_out, out_flags} = head;

    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= {in_a, in_b, in_select, in_out, in_flags};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_count  <= '0;
            drop_count <= '0;
        end else begin
            if (push && in_flags[0] && ovf_count != '1)
                ovf_count <= ovf_count + 1'b1;
            if (in_valid && !in_ready && drop_count != '1)
                drop_count <= drop_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: vector table, directed corner sequences and random
// traffic, all checked against a queue-based reference model.
module tb_alu_result_fifo;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic       clk = 0;
    logic       rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic       in_ready, out_valid, full, empty;
    logic [3:0] in_a = 0, in_b = 0, in_out = 0, out_a, out_b, out_out;
    logic [1:0] in_select = 0, out_select;
    logic [4:0] in_flags = 0, out_flags;
    logic [3:0] count;
    logic [7:0] ovf_count, drop_count;

    int checks = 0;
    int errors = 0;

    logic [18:0] q[$];
    int m_ovf = 0, m_drop = 0;

    always #5 clk = ~clk;

    alu_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_select(in_select), .in_out(in_out), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_select(out_select), .out_out(out_out), .out_flags(out_flags),
        .count(count), .full(full), .empty(empty),
        .ovf_count(ovf_count), .drop_count(drop_count)
    );

    function automatic logic [18:0] mk(input int a, input int b, input int sel, input int o, input int fl);
        logic [3:0] a4 = a[3:0];
        logic [3:0] b4 = b[3:0];
        logic [1:0] s2 = sel[1:0];
        logic [3:0] o4 = o[3:0];
        logic [4:0] f5 = fl[4:0];
        return {a4, b4, s2, o4, f5};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare every DUT output with the model state.
    task automatic chk_model();
        logic [18:0] h;
        h = (q.size() > 0) ? q[0] : 19'd0;
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH && !flush));
        chk("out_entry", 32'({out_a, out_b, out_select, out_out, out_flags}), 32'(h));
        chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
    endtask

    // Apply one cycle of inputs, advance the model by the same edge, then check.
    task automatic step(input logic r, input logic f, input logic v, input logic rdy, input logic [18:0] e);
        bit acc, do_pop;
        rst_n = r; flush = f; in_valid = v; out_ready = rdy;
        {in_a, in_b, in_select, in_out, in_flags} = e;
        if (!r) begin
            q.delete(); m_ovf = 0; m_drop = 0;
        end else begin
            acc = (q.size() < DEPTH) && !f;
            do_pop = (q.size() > 0) && rdy;
            if (v && !acc && m_drop < 255) m_drop++;
            if (v && acc && e[0] && m_ovf < 255) m_ovf++;
            if (f) q.delete();
            else begin
                if (do_pop) void'(q.pop_front());
                if (v && acc) q.push_back(e);
            end
        end
        @(posedge clk); #1;
        chk_model();
    endtask

    typedef struct {
        logic        r, f, v, rdy;
        logic [18:0] e;
        int          exp_count, exp_valid, exp_out, exp_flags, exp_ready;
    } vec_t;

    initial begin
        vec_t vt[6];
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 19'd0,                  0, 0, 0, 0,  1};
        vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, mk(3, 5, 0, 8, 5'b00010), 1, 1, 8, 2,  1};
        vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 19'd0,                  0, 0, 0, 0,  1};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, mk(9, 9, 3, 13, 5'b10001), 1, 1, 13, 17, 1};
        vt[4] = '{1'b1, 1'b0, 1'b1, 1'b1, mk(1, 2, 1, 6, 5'b01000),  1, 1, 6, 8,  1};
        vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 19'd0,                  0, 0, 0, 0,  0};

        @(posedge clk); #1;

        // Test 1 plus a few single-cycle vectors.
        foreach (vt[i]) begin
            step(vt[i].r, vt[i].f, vt[i].v, vt[i].rdy, vt[i].e);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].exp_count));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].exp_valid));
            chk($sformatf("vec%0d_out", i), 32'(out_out), 32'(vt[i].exp_out));
            chk($sformatf("vec%0d_flags", i), 32'(out_flags), 32'(vt[i].exp_flags));
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vt[i].exp_ready));
        end

        // Test 2: fill, drop one, drain in order.
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, mk(i, 0, 0, i, 0));
        chk("t2_full", 32'(full), 1);
        chk("t2_in_ready", 32'(in_ready), 0);
        step(1, 0, 1, 0, mk(0, 0, 0, 15, 0));
        chk("t2_drop", 32'(drop_count), 1);
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain_seq", 32'(out_out), 32'(i));
            step(1, 0, 0, 1, 0);
        end
        chk("t2_empty", 32'(empty), 1);

        // Test 3: steady count=3 with simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, mk(0, 0, 0, i, 0));
        for (int k = 0; k < 20; k++) begin
            chk("t3_order", 32'(out_out), 32'(k & 15));
            step(1, 0, 1, 1, mk(0, 0, 0, (k + 3) & 15, 0));
            chk("t3_count", 32'(count), 3);
        end

        // Test 4: overflow counting, then drop counter saturation.
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 0, mk(i, i, 1, i, (i < 4) ? 1 : 0));
        chk("t4_ovf", 32'(ovf_count), 4);
        for (int i = 0; i < 2; i++) step(1, 0, 1, 0, mk(7, 7, 2, 7, 0));
        for (int i = 0; i < 300; i++) step(1, 0, 1, 0, mk(1, 1, 1, 1, 1));
        chk("t4_drop_sat", 32'(drop_count), 255);
        chk("t4_ovf_hold", 32'(ovf_count), 4);

        // Test 5: flush with push and pop requested in the same cycle.
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, mk(i, 1, 0, i, 1));
        chk("t5_count5", 32'(count), 5);
        step(1, 1, 1, 1, mk(2, 2, 2, 2, 1));
        chk("t5_count0", 32'(count), 0);
        chk("t5_empty", 32'(empty), 1);
        chk("t5_drop", 32'(drop_count), 1);
        chk("t5_ovf", 32'(ovf_count), 5);
        step(1, 0, 0, 0, 0);

        // Test 6: reset mid-stream while pushing and popping.
        for (int i = 0; i < 6; i++) step(1, 0, 1, 0, mk(i, 2, 1, i + 4, 1));
        chk("t6_count6", 32'(count), 6);
        step(0, 0, 1, 1, mk(5, 5, 1, 5, 1));
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_ovf", 32'(ovf_count), 0);
        chk("t6_rst_drop", 32'(drop_count), 0);
        chk("t6_rst_out", 32'(out_out), 0);
        step(1, 0, 1, 0, mk(10, 11, 2, 12, 4));
        chk("t6_first_valid", 32'(out_valid), 1);
        chk("t6_first_out", 32'(out_out), 12);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 128) != 0, ($urandom % 32) == 0, ($urandom % 4) != 0,
                 ($urandom % 3) != 0, 19'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
